// File: rtl/gaussian_filter.sv
// Gaussian pulse shaper ahead of the GFSK modulator: one NRZ bit per symbol,
// upsampled x8 and filtered by a fixed 16-tap Gaussian FIR (BT = 0.5).
module gaussian_filter #(
  parameter int SAMPLE_DIV = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  output logic [15:0] filtered_out,
  output logic        filtered_valid,
  output logic        underrun
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic signed [16:0] C_TAPS [0:15] = '{
    17'sd12,   17'sd56,   17'sd213,  17'sd648,
    17'sd1578, 17'sd3077, 17'sd4801, 17'sd5998,
    17'sd5998, 17'sd4801, 17'sd3077, 17'sd1578,
    17'sd648,  17'sd213,  17'sd56,   17'sd12
  };

  logic [DIV_W-1:0]    r_div_cnt;
  logic [2:0]          r_sps_cnt;
  logic                r_sym;
  logic [15:0]         r_hist;
  logic [15:0]         r_filtered_out;
  logic                r_filtered_valid;

  logic                w_tick;
  logic                w_boundary;
  logic                w_sym_now;
  logic [15:0]         w_hist_next;
  logic signed [16:0]  w_acc;

  assign w_tick     = (r_div_cnt == DIV_LAST);
  // Gate with reset so no handshake is offered in a cycle that reset discards.
  assign w_boundary = w_tick && (r_sps_cnt == 3'd0) && !reset;
  assign w_sym_now  = (w_boundary && bit_valid) ? bit_in : r_sym;
  assign w_hist_next = {r_hist[14:0], w_sym_now};

  assign bit_ready      = w_boundary;
  assign underrun       = w_boundary && !bit_valid;
  assign filtered_out   = r_filtered_out;
  assign filtered_valid = r_filtered_valid;

  // The output register loads at the tick edge, so sum over the post-shift history.
  always_comb begin
    w_acc = '0;
    for (int k = 0; k < 16; k++) begin
      if (w_hist_next[k]) w_acc = w_acc + C_TAPS[k];
      else                w_acc = w_acc - C_TAPS[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt        <= '0;
      r_sps_cnt        <= 3'd0;
      r_sym            <= 1'b0;
      r_hist           <= 16'h0000;
      r_filtered_out   <= 16'h8002;
      r_filtered_valid <= 1'b0;
    end else begin
      r_filtered_valid <= w_tick;
      if (w_tick) begin
        r_div_cnt      <= '0;
        r_sps_cnt      <= r_sps_cnt + 3'd1;
        r_sym          <= w_sym_now;
        r_hist         <= w_hist_next;
        r_filtered_out <= w_acc[15:0];
      end else begin
        r_div_cnt      <= r_div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gaussian_filter.sv
// Scoreboard bench for gaussian_filter: a sample-level FIR model predicts each
// output and every handshake pulse; a monitor pops and compares on filtered_valid.
module tb_gaussian_filter;

  localparam int D = 125;
  localparam int TAPS [16] = '{12, 56, 213, 648, 1578, 3077, 4801, 5998,
                               5998, 4801, 3077, 1578, 648, 213, 56, 12};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_ready;
  logic [15:0] filtered_out;
  logic        filtered_valid;
  logic        underrun;

  gaussian_filter #(.SAMPLE_DIV(D)) dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .filtered_out(filtered_out),
    .filtered_valid(filtered_valid), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;
  int expq[$];

  // model state: cycle count since reset release, current symbol, sample window
  int cyc = 0;
  bit prev_tick = 1'b0;
  bit sym_m = 1'b0;
  int win [16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin : model
      bit tick;
      bit bnd;
      int acc;
      chk("filtered_valid", int'(filtered_valid), int'(prev_tick));
      tick = !reset && ((cyc % D) == D - 1);
      bnd  = tick && (((cyc / D) % 8) == 0);
      chk("bit_ready", int'(bit_ready), int'(bnd));
      chk("underrun", int'(underrun), int'(bnd && !bit_valid));
      if (reset) begin
        sym_m = 1'b0;
        for (int k = 0; k < 16; k++) win[k] = -1;
        cyc = 0;
      end else begin
        if (tick) begin
          if (bnd && bit_valid) sym_m = bit_in;
          for (int k = 15; k > 0; k--) win[k] = win[k-1];
          win[0] = sym_m ? 1 : -1;
          acc = 0;
          for (int k = 0; k < 16; k++) acc += TAPS[k] * win[k];
          expq.push_back(acc);
        end
        cyc++;
      end
      prev_tick = tick;
    end
  end

  always @(negedge clk) begin
    if (armed && filtered_valid === 1'b1) begin : monitor
      int e;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual %0d required none", $signed(filtered_out));
      end else begin
        e = expq.pop_front();
        chk("filtered_out", int'($signed(filtered_out)), e);
      end
    end
  end

  task automatic do_reset(input int n);
    @(posedge clk);
    #1 reset = 1'b1;
    bit_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic get_out(output int v);
    bit ok;
    ok = 1'b0;
    v = 0;
    for (int i = 0; i < 2 * D; i++) begin
      @(negedge clk);
      if (filtered_valid === 1'b1) begin
        v = int'($signed(filtered_out));
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("output_timeout", 0, 1);
  endtask

  task automatic send_bit(input bit b);
    bit got;
    got = 1'b0;
    bit_valid = 1'b1;
    bit_in = b;
    for (int i = 0; i < 8 * D + 4; i++) begin
      @(posedge clk);
      if (bit_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("handshake_timeout", 0, 1);
    #1;
  endtask

  task automatic send_gap();
    bit got;
    got = 1'b0;
    bit_valid = 1'b0;
    for (int i = 0; i < 8 * D + 4; i++) begin
      @(posedge clk);
      if (bit_ready === 1'b1) begin
        got = 1'b1;
        chk("gap_underrun", int'(underrun), 1);
        break;
      end
    end
    if (!got) chk("gap_timeout", 0, 1);
    #1;
  endtask

  task automatic run_alt(input bit b0, output int o [48]);
    do_reset(3);
    fork
      begin
        for (int i = 0; i < 6; i++) send_bit(b0 ^ bit'(i % 2));
        bit_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 48; i++) get_out(o[i]);
      end
    join
  endtask

  task automatic after_release(input string tag, input int first_exp);
    int first_br;
    int first_fv;
    int v;
    first_br = -1;
    first_fv = -1;
    v = 0;
    for (int n = 0; n < 130; n++) begin
      @(negedge clk);
      if (n == 0) begin
        chk({tag, "_out_reset"}, int'(filtered_out), 32'h8002);
        chk({tag, "_pulses_reset"}, int'({bit_ready, filtered_valid, underrun}), 0);
      end
      if (bit_ready === 1'b1 && first_br < 0) first_br = n;
      if (filtered_valid === 1'b1 && first_fv < 0) begin
        first_fv = n;
        v = int'($signed(filtered_out));
      end
    end
    chk({tag, "_first_ready"}, first_br, D - 1);
    chk({tag, "_first_valid"}, first_fv, D);
    chk({tag, "_first_out"}, v, first_exp);
  endtask

  initial begin : main
    int v;
    int s;
    int outa [48];
    int outb [48];
    @(posedge clk);
    armed = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    bit_valid = 1'b1;
    bit_in = 1'b1;

    // step from idle history, then steady ones
    after_release("init", -32766 + 2 * TAPS[0]);
    for (int k = 1; k < 24; k++) begin
      get_out(v);
      s = -32766;
      for (int i = 0; i <= k && i < 16; i++) s += 2 * TAPS[i];
      chk("step", v, s);
    end

    // alternating stream and its inversion
    run_alt(1'b1, outa);
    run_alt(1'b0, outb);
    for (int i = 16; i < 48; i++) begin
      chk("alt_antisym", outa[i] + outb[i], 0);
      chk("alt_bound", int'(outa[i] < 32766 && outa[i] > -32766), 1);
    end

    // underrun while streaming ones repeats the held 1
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    fork
      begin
        send_gap();
        send_bit(1'b1);
        send_bit(1'b1);
      end
      begin
        for (int i = 0; i < 24; i++) begin
          get_out(v);
          chk("ones_hold", v, 32766);
        end
      end
    join

    // reset mid-symbol with a bit held on the input
    send_bit(1'b0);
    repeat (3 * D + D / 2) @(posedge clk);
    #1 reset = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    after_release("midrst", -32766 + 2 * TAPS[0]);

    // random bits with occasional gaps
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 4) == 0) send_gap();
      else send_bit(bit'($urandom_range(0, 1)));
    end

    do_reset(2);
    @(negedge clk);
    chk("queue_empty", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
